// File: rtl/matrix_loader.sv
// Byte-stream loader for operand banks A and B. A frame is N*N A bytes followed by N*N B bytes.
// Bytes are accepted every cycle in LOAD_A/LOAD_B. mat_valid rises on the edge that accepts the last B byte.
// Backpressure: s_ready drops for the whole FULL phase and returns the cycle after mat_ack.
module matrix_loader #(
  parameter int DW = 8,
  parameter int N  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          mat_valid,
  input  logic          mat_ack,
  input  logic          rd_sel,
  input  logic [3:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          frame_err,
  input  logic          clr_err,
  output logic [7:0]    frame_cnt
);

  localparam int NN = N * N;
  localparam logic [3:0] LAST_IDX = 4'(NN - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, FULL} state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [DW-1:0] bank_a [NN];
  logic [DW-1:0] bank_b [NN];

  logic xfer;
  logic final_pos;
  logic bad_last;

  assign s_ready = (state != FULL);

  always_comb begin
    xfer      = s_valid && s_ready;
    final_pos = (state == LOAD_B) && (idx == LAST_IDX);
    // s_last must appear exactly on the final B byte and nowhere else
    bad_last  = xfer && (s_last != final_pos);
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < 5'(NN))
      rd_data = rd_sel ? bank_b[rd_addr] : bank_a[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      idx       <= '0;
      mat_valid <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < NN; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else begin
      // A new error in the same cycle overrides the clear below
      if (clr_err)
        frame_err <= 1'b0;

      if (xfer) begin
        if (state == LOAD_A)
          bank_a[idx] <= s_data;
        else
          bank_b[idx] <= s_data;

        if (bad_last) begin
          frame_err <= 1'b1;
          idx       <= '0;
          state     <= LOAD_A;
        end else if (idx == LAST_IDX) begin
          idx <= '0;
          if (state == LOAD_A) begin
            state <= LOAD_B;
          end else begin
            state     <= FULL;
            mat_valid <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end
        end else begin
          idx <= idx + 4'd1;
        end
      end else if ((state == FULL) && mat_ack) begin
        state     <= LOAD_A;
        mat_valid <= 1'b0;
        idx       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: a frame-position model predicts every output each cycle,
// and literal expectations pin key values along the way.
module tb_matrix_loader;

  localparam int NN = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       mat_valid;
  logic       mat_ack = 1'b0;
  logic       rd_sel = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       frame_err;
  logic       clr_err = 1'b0;
  logic [7:0] frame_cnt;

  matrix_loader #(.DW(8), .N(3)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .mat_valid(mat_valid), .mat_ack(mat_ack), .rd_sel(rd_sel),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_err(frame_err), .clr_err(clr_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [4:0] rd_ctr = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: a frame is a position 0..2*NN-1; the final position must carry s_last.
  int         m_pos = 0;
  bit         m_full = 0;
  bit         m_err = 0;
  int         m_cnt = 0;
  logic [7:0] ma [NN];
  logic [7:0] mb [NN];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_full = 0; m_err = 0; m_cnt = 0;
      for (int i = 0; i < NN; i++) begin ma[i] = 8'h00; mb[i] = 8'h00; end
    end else begin
      bit new_err;
      new_err = 0;
      if (m_full) begin
        if (mat_ack) begin m_full = 0; m_pos = 0; end
      end else if (s_valid) begin
        bit is_final;
        is_final = (m_pos == 2 * NN - 1);
        if (m_pos < NN) ma[m_pos] = s_data; else mb[m_pos - NN] = s_data;
        if (s_last != is_final) begin new_err = 1; m_pos = 0; end
        else if (is_final) begin m_full = 1; m_cnt = (m_cnt + 1) % 256; m_pos = 0; end
        else m_pos++;
      end
      if (new_err) m_err = 1;
      else if (clr_err) m_err = 0;
    end
  end

  function automatic logic [7:0] m_rd(input logic sel, input logic [3:0] addr);
    if (addr >= NN) return 8'h00;
    return sel ? mb[addr] : ma[addr];
  endfunction

  always @(negedge clk) begin
    chk("s_ready",   32'(s_ready),   32'(!m_full));
    chk("mat_valid", 32'(mat_valid), 32'(m_full));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("rd_data",   32'(rd_data),   32'(m_rd(rd_sel, rd_addr)));
  end

  // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic a, input logic c);
    s_valid = v; s_data = d; s_last = l; mat_ack = a; clr_err = c;
    rd_sel = rd_ctr[4]; rd_addr = rd_ctr[3:0]; rd_ctr++;
    @(posedge clk); #1;
  endtask

  task automatic peek(input string nm, input logic sel, input logic [3:0] addr,
                      input logic [7:0] exp);
    s_valid = 1'b0; s_last = 1'b0; mat_ack = 1'b0; clr_err = 1'b0;
    rd_sel = sel; rd_addr = addr;
    @(negedge clk);
    chk(nm, 32'(rd_data), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input int last_at,
                            input logic ack_last);
    for (int i = 0; i < n; i++)
      step(1'b1, 8'(base + i), i == last_at, ack_last && (i == n - 1), 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_mat_valid", 32'(mat_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int t0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_cnt", 32'(frame_cnt), 32'h0);
    chk("reset_ready", 32'(s_ready), 32'h1);

    // 1: clean frame; ack held on the entry cycle must be ignored
    for (int i = 0; i < NN; i++) step(1'b1, 8'(8'h01 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NN; i++) step(1'b1, 8'(8'h11 + i), i == NN - 1, i == NN - 1, 1'b0);
    chk("t1_mat_valid", 32'(mat_valid), 32'h1);
    chk("t1_s_ready", 32'(s_ready), 32'h0);
    chk("t1_cnt", 32'(frame_cnt), 32'h1);
    peek("t1_a4", 1'b0, 4'd4, 8'h05);
    peek("t1_b8", 1'b1, 4'd8, 8'h19);
    peek("t1_a9", 1'b0, 4'd9, 8'h00);

    // 2: stream ignored while FULL, then release
    repeat (5) step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    peek("t2_a0", 1'b0, 4'd0, 8'h01);
    peek("t2_b0", 1'b1, 4'd0, 8'h11);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t2_mat_valid", 32'(mat_valid), 32'h0);
    chk("t2_s_ready", 32'(s_ready), 32'h1);

    // 3: s_last early on B[0]; erroneous byte still stored
    send_frame(10, 8'h30, 9, 1'b0);
    chk("t3_err", 32'(frame_err), 32'h1);
    chk("t3_mat_valid", 32'(mat_valid), 32'h0);
    peek("t3_a0", 1'b0, 4'd0, 8'h30);
    peek("t3_b0", 1'b1, 4'd0, 8'h39);
    send_frame(18, 8'h40, 17, 1'b0);
    chk("t3_full", 32'(mat_valid), 32'h1);
    chk("t3_err_held", 32'(frame_err), 32'h1);
    chk("t3_cnt", 32'(frame_cnt), 32'h2);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t3_clr", 32'(frame_err), 32'h0);

    // 4: missing s_last on the final byte
    send_frame(18, 8'h60, -1, 1'b0);
    chk("t4_err", 32'(frame_err), 32'h1);
    chk("t4_mat_valid", 32'(mat_valid), 32'h0);
    chk("t4_cnt", 32'(frame_cnt), 32'h2);
    // set wins over a simultaneous clear
    step(1'b1, 8'h70, 1'b1, 1'b0, 1'b1);
    chk("t4_set_wins", 32'(frame_err), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t4_clr", 32'(frame_err), 32'h0);

    // 5: reset mid-load, then a fresh frame
    send_frame(7, 8'h80, -1, 1'b0);
    do_reset();
    peek("t5_a0_zero", 1'b0, 4'd0, 8'h00);
    peek("t5_a6_zero", 1'b0, 4'd6, 8'h00);
    send_frame(18, 8'hA0, 17, 1'b0);
    chk("t5_full", 32'(mat_valid), 32'h1);
    chk("t5_cnt", 32'(frame_cnt), 32'h1);
    peek("t5_a0", 1'b0, 4'd0, 8'hA0);
    peek("t5_b8", 1'b1, 4'd8, 8'hB1);
    do_reset();
    chk("t5_cnt_rst", 32'(frame_cnt), 32'h0);

    // 6: 256 back-to-back frames with immediate ack
    t0 = cyc;
    for (int f = 0; f < 256; f++) begin
      send_frame(18, 8'(f), 17, 1'b0);
      if (f == 254) chk("t6_cnt255", 32'(frame_cnt), 32'hFF);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("t6_cnt_wrap", 32'(frame_cnt), 32'h0);
    chk("t6_err", 32'(frame_err), 32'h0);
    chk("t6_cycles", 32'(cyc - t0), 32'(256 * 19));

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
